// File: rtl/resp_framer_pkg.sv
// Shared definitions for the response framer: FSM state encoding and default byte width.
// Ports: none (package only).
// Imported by the framer top and its holding-register sub-module.
package resp_framer_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ALU_LO = 2'd1;
  localparam logic [1:0] ST_ALU_HI = 2'd2;
  localparam logic [1:0] ST_RD     = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ALU_LO = ST_ALU_LO,
    ALU_HI = ST_ALU_HI,
    RD     = ST_RD
  } state_t;

endpackage

// File: rtl/resp_framer_if.sv
// Bundle of result inputs, FIFO write-port outputs and status flags of the response framer.
// Ports: ALU_OUT/ALU_OUT_Valid, Rd_Reg/Rd_Reg_Valid, FIFO_FULL in; FIFO_WR_DATA/FIFO_WR_INC, Busy, Overflow out.
// slave = framer side, master = producer/FIFO side driving the inputs.
interface resp_framer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_Valid;
  logic [DATA_WIDTH-1:0]   Rd_Reg;
  logic                    Rd_Reg_Valid;
  logic                    FIFO_FULL;
  logic [DATA_WIDTH-1:0]   FIFO_WR_DATA;
  logic                    FIFO_WR_INC;
  logic                    Busy;
  logic                    Overflow;

  modport slave (
    input  ALU_OUT, ALU_OUT_Valid, Rd_Reg, Rd_Reg_Valid, FIFO_FULL,
    output FIFO_WR_DATA, FIFO_WR_INC, Busy, Overflow
  );

  modport master (
    output ALU_OUT, ALU_OUT_Valid, Rd_Reg, Rd_Reg_Valid, FIFO_FULL,
    input  FIFO_WR_DATA, FIFO_WR_INC, Busy, Overflow
  );

endinterface

// File: rtl/resp_framer_buf.sv
// One-entry holding register (module resp_buf): load sets valid, clear drops it, load onto a full entry is dropped.
// Ports: CLK, RST (async active-low), load/din in, clear in, vld/dat out, drop out (combinational).
// A load in the same cycle as clear is accepted, so a draining entry can be refilled without loss.
module resp_buf #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic             drop
);

  logic accept;

  // Entry occupied and not being drained this cycle: the new value has nowhere to go.
  assign drop   = load & vld & ~clear;
  assign accept = load & ~drop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (accept) begin
      vld <= 1'b1;
      dat <= din;
    end else if (clear) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/resp_framer.sv
// Response framer: buffers one ALU (2 bytes) and one Rd result, serialises them low byte first into the FIFO.
// Ports: CLK, RST (async active-low), bus (resp_framer_if.slave). FIFO_WR_DATA/FIFO_WR_INC registered.
// Strobe-to-write latency 2 cycles; FIFO_FULL stalls the current byte, ALU frames are never split by a Rd byte.
module resp_framer
  import resp_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  resp_framer_if.slave  bus
);

  state_t state, cur, nxt;

  logic                    alu_pend, rd_pend;
  logic [2*DATA_WIDTH-1:0] alu_dat;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic                    alu_drop, rd_drop;
  logic                    alu_clr, rd_clr;
  logic                    wr_inc_d;
  logic [DATA_WIDTH-1:0]   wr_dat_d;

  resp_buf #(.WIDTH(2*DATA_WIDTH)) u_alu_buf (
    .CLK   (CLK),
    .RST   (RST),
    .load  (bus.ALU_OUT_Valid),
    .din   (bus.ALU_OUT),
    .clear (alu_clr),
    .vld   (alu_pend),
    .dat   (alu_dat),
    .drop  (alu_drop)
  );

  resp_buf #(.WIDTH(DATA_WIDTH)) u_rd_buf (
    .CLK   (CLK),
    .RST   (RST),
    .load  (bus.Rd_Reg_Valid),
    .din   (bus.Rd_Reg),
    .clear (rd_clr),
    .vld   (rd_pend),
    .dat   (rd_dat),
    .drop  (rd_drop)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    // IDLE dispatches in the same cycle it sees a pending result, so the first
    // byte is written on the edge right after the capture edge.
    cur = state;
    if (state == IDLE) begin
      if (alu_pend) begin
        cur = ALU_LO;
      end else if (rd_pend) begin
        cur = RD;
      end
    end

    nxt      = cur;
    alu_clr  = 1'b0;
    rd_clr   = 1'b0;
    wr_inc_d = 1'b0;
    wr_dat_d = bus.FIFO_WR_DATA;

    case (cur)
      ALU_LO: begin
        if (!bus.FIFO_FULL) begin
          wr_inc_d = 1'b1;
          wr_dat_d = alu_dat[DATA_WIDTH-1:0];
          nxt      = ALU_HI;
        end
      end
      ALU_HI: begin
        if (!bus.FIFO_FULL) begin
          wr_inc_d = 1'b1;
          wr_dat_d = alu_dat[2*DATA_WIDTH-1:DATA_WIDTH];
          alu_clr  = 1'b1;
          // A strobe this cycle refills the draining ALU entry.
          if (bus.ALU_OUT_Valid) begin
            nxt = ALU_LO;
          end else if (rd_pend) begin
            nxt = RD;
          end else begin
            nxt = IDLE;
          end
        end
      end
      RD: begin
        if (!bus.FIFO_FULL) begin
          wr_inc_d = 1'b1;
          wr_dat_d = rd_dat;
          rd_clr   = 1'b1;
          nxt      = alu_pend ? ALU_LO : IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.FIFO_WR_INC  <= 1'b0;
      bus.FIFO_WR_DATA <= '0;
      bus.Overflow     <= 1'b0;
    end else begin
      bus.FIFO_WR_INC  <= wr_inc_d;
      bus.FIFO_WR_DATA <= wr_dat_d;
      if (alu_drop || rd_drop) begin
        bus.Overflow <= 1'b1;
      end
    end
  end

  assign bus.Busy = alu_pend | rd_pend | (state != IDLE);

endmodule

// File: tb/tb_resp_framer.sv
// Directed bench for resp_framer: reset, single ALU frame, full stall, priority, refill, overflow, mid-frame reset.
// Ports: none (top-level bench); drives the master side of resp_framer_if.
// Inputs change 1 time unit after the falling edge; outputs are sampled there as well.
module tb_resp_framer;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  resp_framer_if #(.DATA_WIDTH(DW)) bus ();

  resp_framer #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Write monitor: every accepted FIFO write with the cycle it was seen in.
  int             cyc = 0;
  logic [DW-1:0]  wr_log [$];
  int             wr_cyc [$];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (RST && bus.FIFO_WR_INC) begin
      wr_log.push_back(bus.FIFO_WR_DATA);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_cyc.delete();
  endtask

  task automatic idle_inputs();
    bus.ALU_OUT       = '0;
    bus.ALU_OUT_Valid = 1'b0;
    bus.Rd_Reg        = '0;
    bus.Rd_Reg_Valid  = 1'b0;
    bus.FIFO_FULL     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    step();
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b0) begin miscompares++; $display("FAIL reset_wr_inc got=%b exp=0", bus.FIFO_WR_INC); end
    vectors++; if (bus.FIFO_WR_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data got=%h exp=00", bus.FIFO_WR_DATA); end
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    vectors++; if (bus.Overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", bus.Overflow); end
    RST = 1'b1;
    step();
    step();
  endtask

  task automatic test_alu_basic();
    clear_log();
    bus.ALU_OUT = 16'hA55A; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    vectors++; if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL alu_busy_pending got=%b exp=1", bus.Busy); end
    vectors++; if (bus.FIFO_WR_INC !== 1'b0) begin miscompares++; $display("FAIL alu_no_early_write got=%b exp=0", bus.FIFO_WR_INC); end
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b1 || bus.FIFO_WR_DATA !== 8'h5A) begin miscompares++; $display("FAIL alu_lo_byte got inc=%b data=%h exp inc=1 data=5a", bus.FIFO_WR_INC, bus.FIFO_WR_DATA); end
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b1 || bus.FIFO_WR_DATA !== 8'hA5) begin miscompares++; $display("FAIL alu_hi_byte got inc=%b data=%h exp inc=1 data=a5", bus.FIFO_WR_INC, bus.FIFO_WR_DATA); end
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b0) begin miscompares++; $display("FAIL alu_end_inc got=%b exp=0", bus.FIFO_WR_INC); end
    vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL alu_end_busy got=%b exp=0", bus.Busy); end
    vectors++; if (wr_log.size() != 2) begin miscompares++; $display("FAIL alu_write_count got=%0d exp=2", wr_log.size()); end
  endtask

  task automatic test_full_stall();
    clear_log();
    bus.FIFO_FULL = 1'b1;
    bus.Rd_Reg = 8'h3C; bus.Rd_Reg_Valid = 1'b1;
    step();
    bus.Rd_Reg_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.FIFO_WR_INC !== 1'b0) begin miscompares++; $display("FAIL full_no_write cycle=%0d got=%b exp=0", i, bus.FIFO_WR_INC); end
      if (i == 4) bus.FIFO_FULL = 1'b0;
      else step();
    end
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b1 || bus.FIFO_WR_DATA !== 8'h3C) begin miscompares++; $display("FAIL full_release_write got inc=%b data=%h exp inc=1 data=3c", bus.FIFO_WR_INC, bus.FIFO_WR_DATA); end
    step();
    step();
    vectors++; if (wr_log.size() != 1) begin miscompares++; $display("FAIL full_single_write got=%0d exp=1", wr_log.size()); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] exp_b [3];
    exp_b[0] = 8'h34; exp_b[1] = 8'h12; exp_b[2] = 8'h77;
    clear_log();
    bus.ALU_OUT = 16'h1234; bus.ALU_OUT_Valid = 1'b1;
    bus.Rd_Reg  = 8'h77;    bus.Rd_Reg_Valid  = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0; bus.Rd_Reg_Valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    vectors++; if (wr_log.size() != 3) begin miscompares++; $display("FAIL prio_count got=%0d exp=3", wr_log.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_log.size()) begin
        vectors++; if (wr_log[i] !== exp_b[i]) begin miscompares++; $display("FAIL prio_byte%0d got=%h exp=%h", i, wr_log[i], exp_b[i]); end
      end
    end
    if (wr_cyc.size() == 3) begin
      vectors++; if (wr_cyc[2] - wr_cyc[0] != 2) begin miscompares++; $display("FAIL prio_contiguous got span=%0d exp=2", wr_cyc[2] - wr_cyc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_b [4];
    exp_b[0] = 8'h22; exp_b[1] = 8'h11; exp_b[2] = 8'h44; exp_b[3] = 8'h33;
    clear_log();
    bus.ALU_OUT = 16'h1122; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    step();
    // FSM now in ALU_HI; this strobe lands on the cycle the entry drains.
    bus.ALU_OUT = 16'h3344; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (wr_log.size() != 4) begin miscompares++; $display("FAIL b2b_count got=%0d exp=4", wr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_log.size()) begin
        vectors++; if (wr_log[i] !== exp_b[i]) begin miscompares++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, wr_log[i], exp_b[i]); end
      end
    end
    vectors++; if (bus.Overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_no_overflow got=%b exp=0", bus.Overflow); end
  endtask

  task automatic test_overflow();
    clear_log();
    bus.FIFO_FULL = 1'b1;
    bus.ALU_OUT = 16'h0001; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    step();
    vectors++; if (bus.Overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_not_yet got=%b exp=0", bus.Overflow); end
    bus.ALU_OUT = 16'h0002; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    vectors++; if (bus.Overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", bus.Overflow); end
    bus.FIFO_FULL = 1'b0;
    for (int i = 0; i < 6; i++) step();
    vectors++; if (wr_log.size() != 2) begin miscompares++; $display("FAIL ovf_count got=%0d exp=2", wr_log.size()); end
    if (wr_log.size() == 2) begin
      vectors++; if (wr_log[0] !== 8'h01 || wr_log[1] !== 8'h00) begin miscompares++; $display("FAIL ovf_bytes got=%h,%h exp=01,00", wr_log[0], wr_log[1]); end
    end
    vectors++; if (bus.Overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", bus.Overflow); end
  endtask

  task automatic test_mid_reset();
    clear_log();
    bus.ALU_OUT = 16'hBEEF; bus.ALU_OUT_Valid = 1'b1;
    step();
    bus.ALU_OUT_Valid = 1'b0;
    step();
    vectors++; if (bus.FIFO_WR_INC !== 1'b1 || bus.FIFO_WR_DATA !== 8'hEF) begin miscompares++; $display("FAIL mrst_lo_byte got inc=%b data=%h exp inc=1 data=ef", bus.FIFO_WR_INC, bus.FIFO_WR_DATA); end
    RST = 1'b0;
    #1;
    vectors++; if (bus.FIFO_WR_INC !== 1'b0 || bus.FIFO_WR_DATA !== 8'h00) begin miscompares++; $display("FAIL mrst_outputs got inc=%b data=%h exp inc=0 data=00", bus.FIFO_WR_INC, bus.FIFO_WR_DATA); end
    vectors++; if (bus.Busy !== 1'b0 || bus.Overflow !== 1'b0) begin miscompares++; $display("FAIL mrst_status got busy=%b ovf=%b exp 0,0", bus.Busy, bus.Overflow); end
    clear_log();
    step();
    step();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (wr_log.size() != 0) begin miscompares++; $display("FAIL mrst_abandoned got=%0d writes exp=0", wr_log.size()); end
    bus.Rd_Reg = 8'h11; bus.Rd_Reg_Valid = 1'b1;
    step();
    bus.Rd_Reg_Valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (wr_log.size() != 1) begin miscompares++; $display("FAIL mrst_rd_count got=%0d exp=1", wr_log.size()); end
    if (wr_log.size() == 1) begin
      vectors++; if (wr_log[0] !== 8'h11) begin miscompares++; $display("FAIL mrst_rd_byte got=%h exp=11", wr_log[0]); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu_basic();
    test_full_stall();
    test_priority();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/resp_framer.md
Name: resp_framer

Overview:
- Response stage in the REF_CLK domain, directly upstream of the async FIFO write port.
- Accepts 2*DATA_WIDTH ALU results and DATA_WIDTH register-file read data, serializes them into bytes and writes them to the FIFO under FIFO_FULL backpressure.
- Offloads byte sequencing from the system controller.
- Holds one pending result per source, so back-to-back results are not lost while the FIFO is stalled.

Parameters:
- DATA_WIDTH, 8, byte width of the FIFO data path and of Rd_Reg; ALU_OUT is 2*DATA_WIDTH.

Ports:
- CLK  input  1  REF_CLK-domain clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- ALU_OUT  input  2*DATA_WIDTH  ALU result.
- ALU_OUT_Valid  input  1  one-cycle strobe qualifying ALU_OUT.
- Rd_Reg  input  DATA_WIDTH  register-file read data.
- Rd_Reg_Valid  input  1  one-cycle strobe qualifying Rd_Reg.
- FIFO_FULL  input  1  async FIFO full flag, write-domain synchronized.
- FIFO_WR_DATA  output  DATA_WIDTH  byte to FIFO, registered.
- FIFO_WR_INC  output  1  one-cycle FIFO write strobe, registered.
- Busy  output  1  high while any byte is pending or being sent.
- Overflow  output  1  sticky; set when a result is dropped.

Behaviour:
- Reset (RST low, async):
  - FIFO_WR_DATA=0, FIFO_WR_INC=0, Busy=0, Overflow=0.
  - Both pending buffers invalid; FSM in IDLE.
- Capture:
  - ALU_OUT_Valid loads alu_buf and sets alu_pend. Rd_Reg_Valid loads rd_buf and sets rd_pend.
  - A strobe arriving while its buffer is already pending and not being drained that cycle is dropped. The buffer keeps the old value and Overflow is set.
  - Overflow clears only on reset.
- FSM states: IDLE, ALU_LO, ALU_HI, RD.
  - IDLE: if alu_pend go to ALU_LO; else if rd_pend go to RD. ALU has priority on simultaneous pending.
  - ALU_LO: when !FIFO_FULL, drive FIFO_WR_DATA=alu_buf[DATA_WIDTH-1:0] and FIFO_WR_INC=1, go to ALU_HI. When FIFO_FULL, hold state with FIFO_WR_INC=0.
  - ALU_HI: when !FIFO_FULL, write alu_buf[2*DATA_WIDTH-1:DATA_WIDTH] and clear alu_pend. Then go to ALU_LO if a new ALU result was captured this cycle, else RD if rd_pend, else IDLE.
  - RD: when !FIFO_FULL, write rd_buf and clear rd_pend. Then go to ALU_LO if alu_pend, else IDLE.
- Byte order: low byte first. An ALU frame is never interleaved with a RD byte.
- Latency:
  - A strobe in cycle N with FSM in IDLE and FIFO not full gives FIFO_WR_INC=1 in cycle N+2 (capture edge, then write edge).
  - ALU hi byte follows in cycle N+3.
- FIFO_WR_INC is never asserted in a cycle where FIFO_FULL was sampled high. It is never high for two writes of the same byte.
- Draining buffer: a new strobe arriving in the same cycle its buffer is being cleared is accepted, not dropped. The new value is captured and pend stays set.
- Busy = alu_pend | rd_pend | (state != IDLE).
- Mid-frame reset returns all state to reset values immediately. A partially sent ALU frame is abandoned.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ALU_LO/ALU_HI/RD, 2-bit localparams).
  - DATA_WIDTH default.
- One natural sub-module: resp_buf, a one-entry holding register with valid, load, clear, drop-detect. Instantiated twice (ALU width and Rd width, parameterized by width).

Test Plan:
- Reset release, ALU_OUT=16'hA55A strobe, FIFO_FULL=0 -> FIFO_WR_INC pulses in two consecutive cycles with data 8'h5A then 8'hA5. Busy falls the cycle after.
- Rd_Reg=8'h3C strobe with FIFO_FULL=1 for 5 cycles, then 0 -> no FIFO_WR_INC while full. A single write of 8'h3C follows FIFO_FULL low by one cycle.
- ALU_OUT=16'h1234 and Rd_Reg=8'h77 strobed in the same cycle -> byte sequence 8'h34, 8'h12, 8'h77 with no interleave.
- FIFO_FULL held high, ALU strobes 16'h0001 then 16'h0002 -> Overflow=1; after full clears only 8'h01, 8'h00 are written.
- RST asserted between ALU_LO and ALU_HI of 16'hBEEF -> outputs zero immediately. No 8'hBE write follows; after release a new Rd_Reg=8'h11 strobe produces a single 8'h11 write.
